zorro_rr_arbiter: RTL
=====================

// Module: zorro_rr_arbiter
//
// PURPOSE
// Round-robin Zorro II bus-master arbiter for the A2000 slot DMA requests.
// - Collects slot bus requests and issues a single 68000 bus request.
// - Hands the CPU's bus grant to exactly one slot.
// - Tracks bus tenure through BGACKn.
// - Withdraws grants that a slot never acknowledges.
// Sits between the slot BRn/BGn lines and the CPU BR/BG/BGACK pins.
// It replaces fixed slot-1-first priority with rotating fairness.
//
// PARAMETERS
// NSLOTS        5    number of Zorro slots arbitrated (1..7)
// GRANT_TIMEOUT 16   C7M cycles a slot may hold BGn without asserting BGACKn
// TENURE_LIMIT  255  C7M cycles of ownership before HOG pulses; 0 disables it
// CW            8    width of the grant and tenure counters (>= clog2 of both)
//
// PORTS
// C7M      in   1       7.09 MHz system clock; all state changes on posedge
// RESET    in   1       async, active-high; clears all state immediately
// BRn      in   NSLOTS  slot bus requests, active-low, asynchronous to C7M
// CPU_BGn  in   1       68000 bus grant, active-low, asynchronous
// BGACKn   in   1       bus grant acknowledge, active-low, asynchronous
// CPU_BRn  out  1       bus request to the 68000, active-low
// BGn      out  NSLOTS  per-slot bus grant, active-low, at most one low
// OWNER    out  3       slot number (1..NSLOTS) being served; 0 when idle
// BUSY     out  1       high in every state except IDLE
// TIMEOUT  out  1       one-cycle pulse when a grant is withdrawn unacknowledged
// HOG      out  1       one-cycle pulse when tenure reaches TENURE_LIMIT
//
// BEHAVIOUR
// Reset values:
// - CPU_BRn=1, BGn=all 1, OWNER=0, BUSY=0, TIMEOUT=0, HOG=0.
// - State=IDLE, pointer=NSLOTS, so slot 1 has first priority.
// Synchronisation:
// - BRn, CPU_BGn and BGACKn each pass through 2 flops before any use.
// - Decisions below use the synchronised values; +2 cycles of input latency.
// Winner selection:
// - Scan slots ptr+1, ptr+2, ... circularly, wrapping NSLOTS->1.
// - The first slot with BRn low wins.
// States (all registered outputs):
// - IDLE:
//   - If any BRn is low: latch the winner, set OWNER=winner, CPU_BRn=0, go to REQ.
// - REQ:
//   - If the winner's BRn is back high: CPU_BRn=1, OWNER=0, go to IDLE.
//     The pointer is unchanged.
//   - Else, if CPU_BGn is low: BGn[winner]=0, clear the grant counter, go to GRANT.
// - GRANT:
//   - If BGACKn is low: BGn[winner]=1, CPU_BRn=1, clear the tenure counter, go to OWNED.
//   - Else, when the grant counter reaches GRANT_TIMEOUT-1:
//     BGn[winner]=1, CPU_BRn=1, TIMEOUT=1 for one cycle, pointer=winner, go to IDLE.
//   - BGACKn low wins if it coincides with the timeout.
// - OWNED:
//   - The tenure counter increments and saturates at 2^CW-1.
//   - On reaching TENURE_LIMIT (non-zero): HOG=1 for one cycle, once per tenure.
//   - The bus is not revoked on HOG.
//   - If BGACKn is high: pointer=winner, OWNER=0, go to IDLE.
// Fairness:
// - New requests arriving during REQ, GRANT or OWNED wait for IDLE.
// - The winner cannot win again while any other slot is requesting.
// Invariants:
// - At most one BGn is low.
// - No BGn is low outside GRANT.
// - CPU_BRn is low only in REQ and GRANT.
// Reset mid-operation:
// - All outputs return to reset values asynchronously.
// - The synchroniser flops are forced to the inactive (high) level.
//
// TESTING
// 1. BRn=5'b11011 (slot 3) -> CPU_BRn low 3 cycles later; drive CPU_BGn low ->
//    BGn[3] low, OWNER=3; drive BGACKn low -> BGn[3] and CPU_BRn high;
//    release BGACKn -> IDLE, OWNER=0.
// 2. Slots 1 and 4 request continuously -> grants alternate 1,4,1,4.
//    Slot 1 never receives two consecutive tenures.
// 3. Grant slot 2 and never assert BGACKn -> BGn[2] returns high exactly
//    16 cycles after it fell. TIMEOUT pulses once; the next grant goes to
//    another requester if one exists.
// 4. Slot 5 withdraws BRn while in REQ, before CPU_BGn -> CPU_BRn high,
//    back to IDLE, no BGn asserted.
// 5. With TENURE_LIMIT=4, hold BGACKn low for 10 cycles -> exactly one HOG
//    pulse on the 4th OWNED cycle; no grant is revoked.
// 6. Assert RESET while in GRANT -> BGn and CPU_BRn high in the same cycle.
//    After release, with all slots requesting, slot 1 is served first.

Source files
------------

// File: rtl/zorro_rr_arbiter.sv
// -----------------------------------------------------------------------------
// zorro_rr_arbiter
//
// Round-robin bus-master arbiter for the A2000 Zorro II slot DMA requests.
// Collects the active-low slot bus requests and raises one 68000 bus request.
// It then hands the CPU's bus grant to exactly one slot and tracks that slot's
// tenure through BGACKn. A grant the slot never acknowledges is withdrawn.
// Slot priority rotates: the most recently served slot goes to the back of the
// queue. This replaces the fixed slot-1-first scheme.
//
// Slot numbering: slot s (1..NSLOTS) uses bit s-1 of BRn and BGn.
//
// Parameters
//   NSLOTS        number of Zorro slots arbitrated (1..7)
//   GRANT_TIMEOUT C7M cycles a slot may hold BGn without asserting BGACKn
//   TENURE_LIMIT  C7M cycles of ownership before HOG pulses; 0 disables HOG
//   CW            width of the grant and tenure counters
//
// Ports
//   C7M      in   7.09 MHz system clock; all state changes on its rising edge
//   RESET    in   asynchronous, active-high; clears all state immediately
//   BRn      in   [NSLOTS] slot bus requests, active-low, asynchronous
//   CPU_BGn  in   68000 bus grant, active-low, asynchronous
//   BGACKn   in   bus grant acknowledge, active-low, asynchronous
//   CPU_BRn  out  bus request to the 68000, active-low
//   BGn      out  [NSLOTS] per-slot bus grant, active-low, at most one low
//   OWNER    out  [3] slot being served (1..NSLOTS); 0 when idle
//   BUSY     out  high whenever the arbiter is not idle
//   TIMEOUT  out  one-cycle pulse when a grant is withdrawn unacknowledged
//   HOG      out  one-cycle pulse when a tenure reaches TENURE_LIMIT cycles
// -----------------------------------------------------------------------------
module zorro_rr_arbiter #(
  parameter int NSLOTS        = 5,
  parameter int GRANT_TIMEOUT = 16,
  parameter int TENURE_LIMIT  = 255,
  parameter int CW            = 8
) (
  input  logic              C7M,
  input  logic              RESET,
  input  logic [NSLOTS-1:0] BRn,
  input  logic              CPU_BGn,
  input  logic              BGACKn,
  output logic              CPU_BRn,
  output logic [NSLOTS-1:0] BGn,
  output logic [2:0]        OWNER,
  output logic              BUSY,
  output logic              TIMEOUT,
  output logic              HOG
);

  typedef enum logic [1:0] {
    IDLE,   // waiting for any slot request
    REQ,    // CPU bus request raised for the latched winner
    GRANT,  // winner holds BGn, waiting for BGACKn
    OWNED   // winner owns the bus until BGACKn rises
  } state_t;

  localparam logic [CW-1:0] GRANT_LAST = CW'(GRANT_TIMEOUT - 1);
  localparam logic [CW-1:0] TENURE_CAP = CW'(TENURE_LIMIT);
  localparam bit            HOG_EN     = (TENURE_LIMIT != 0);
  localparam logic [2:0]    LAST_SLOT  = 3'(NSLOTS);

  // ---------------------------------------------------------------------------
  // Input synchronisers: two flops per asynchronous input.
  // ---------------------------------------------------------------------------
  logic [NSLOTS-1:0] brn_meta, brn_sync;
  logic              bg_meta,  bg_sync;
  logic              ack_meta, ack_sync;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of the flop before it; blocking
  // assignments here would collapse the two synchroniser stages into one.
  // The synchronisers reset to the inactive (high) level so that a request
  // present during reset cannot act until it has passed both stages again.
  always_ff @(posedge C7M or posedge RESET) begin
    if (RESET) begin
      brn_meta <= '1;
      brn_sync <= '1;
      bg_meta  <= 1'b1;
      bg_sync  <= 1'b1;
      ack_meta <= 1'b1;
      ack_sync <= 1'b1;
    end else begin
      brn_meta <= BRn;
      brn_sync <= brn_meta;
      bg_meta  <= CPU_BGn;
      bg_sync  <= bg_meta;
      ack_meta <= BGACKn;
      ack_sync <= ack_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t            state_q,   state_d;
  logic [2:0]        ptr_q,     ptr_d;      // last slot served
  logic [2:0]        win_q,     win_d;      // slot currently being served
  logic [CW-1:0]     gcnt_q,    gcnt_d;     // cycles spent in GRANT
  logic [CW-1:0]     tcnt_q,    tcnt_d;     // cycles spent in OWNED
  logic              cpu_brn_q, cpu_brn_d;
  logic [NSLOTS-1:0] bgn_q,     bgn_d;
  logic [2:0]        owner_q,   owner_d;
  logic              busy_q,    busy_d;
  logic              timeout_q, timeout_d;
  logic              hog_q,     hog_d;

  // Requests as an active-high vector indexed directly by slot number; bit 0
  // and any bits above NSLOTS stay zero so a 3-bit slot number can index it.
  logic [7:0] req_vec;
  always_comb begin
    req_vec             = '0;
    req_vec[NSLOTS:1]   = ~brn_sync;
  end

  // Circular scan starting after the last served slot, wrapping NSLOTS -> 1.
  // win_slot is 0 when nobody is requesting.
  logic [2:0] win_slot;
  always_comb begin
    logic [2:0] scan;
    win_slot = '0;
    scan     = ptr_q;
    for (int k = 0; k < NSLOTS; k++) begin
      scan = (scan == LAST_SLOT) ? 3'd1 : scan + 3'd1;
      if (win_slot == 3'd0 && req_vec[scan]) win_slot = scan;
    end
  end

  // One-hot grant for the latched winner, same slot-number indexing.
  logic [7:0] grant_vec;
  assign grant_vec = 8'd1 << win_q;

  // Tenure counter saturates instead of wrapping, so a long tenure can never
  // pass TENURE_LIMIT a second time.
  logic [CW-1:0] tcnt_inc;
  assign tcnt_inc = (tcnt_q == '1) ? tcnt_q : tcnt_q + CW'(1);

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    gcnt_d    = gcnt_q;
    tcnt_d    = tcnt_q;
    cpu_brn_d = cpu_brn_q;
    bgn_d     = bgn_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
    hog_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_slot != 3'd0) begin
          win_d     = win_slot;
          owner_d   = win_slot;
          cpu_brn_d = 1'b0;
          state_d   = REQ;
        end
      end

      REQ: begin
        // A withdrawn request abandons the cycle without moving the pointer,
        // so the same slot keeps its place in the rotation.
        if (!req_vec[win_q]) begin
          cpu_brn_d = 1'b1;
          owner_d   = '0;
          state_d   = IDLE;
        end else if (!bg_sync) begin
          bgn_d   = ~grant_vec[NSLOTS:1];
          gcnt_d  = '0;
          state_d = GRANT;
        end
      end

      GRANT: begin
        // Acknowledge is tested first so it wins over a coincident timeout.
        if (!ack_sync) begin
          bgn_d     = '1;
          cpu_brn_d = 1'b1;
          tcnt_d    = '0;
          state_d   = OWNED;
        end else if (gcnt_q == GRANT_LAST) begin
          bgn_d     = '1;
          cpu_brn_d = 1'b1;
          timeout_d = 1'b1;
          ptr_d     = win_q;
          owner_d   = '0;
          state_d   = IDLE;
        end else begin
          gcnt_d = gcnt_q + CW'(1);
        end
      end

      OWNED: begin
        tcnt_d = tcnt_inc;
        // Pulse only on the transition onto the limit: once per tenure.
        if (HOG_EN && tcnt_inc == TENURE_CAP && tcnt_q != TENURE_CAP) begin
          hog_d = 1'b1;
        end
        if (ack_sync) begin
          ptr_d   = win_q;
          owner_d = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge C7M or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      ptr_q     <= LAST_SLOT;   // slot 1 is first in line after reset
      win_q     <= '0;
      gcnt_q    <= '0;
      tcnt_q    <= '0;
      cpu_brn_q <= 1'b1;
      bgn_q     <= '1;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hog_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      gcnt_q    <= gcnt_d;
      tcnt_q    <= tcnt_d;
      cpu_brn_q <= cpu_brn_d;
      bgn_q     <= bgn_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      hog_q     <= hog_d;
    end
  end

  assign CPU_BRn = cpu_brn_q;
  assign BGn     = bgn_q;
  assign OWNER   = owner_q;
  assign BUSY    = busy_q;
  assign TIMEOUT = timeout_q;
  assign HOG     = hog_q;

  // ---------------------------------------------------------------------------
  // Bus-protocol invariants
  // ---------------------------------------------------------------------------
  a_one_grant: assert property (@(posedge C7M) disable iff (RESET)
    $onehot0(~bgn_q));

  a_grant_only_in_grant: assert property (@(posedge C7M) disable iff (RESET)
    (bgn_q != '1) |-> (state_q == GRANT));

  a_cpu_br_scope: assert property (@(posedge C7M) disable iff (RESET)
    (!cpu_brn_q) |-> (state_q == REQ || state_q == GRANT));

endmodule
